// File: rtl/stopwatch_pkg.sv
// Shared types and limits for the stopwatch time-keeping core.
package stopwatch_pkg;

  // Control states of the stopwatch core
  typedef enum logic [1:0] {
    PAUSED = 2'd0,
    RUN    = 2'd1,
    ADJUST = 2'd2
  } state_t;

  // Width of one BCD digit
  localparam int BCD_W = 4;

  // Highest value of the seconds-tens digit (0-5)
  localparam int SEC_TENS_MAX = 5;

  // Highest value of every other digit (0-9)
  localparam int DIGIT_MAX = 9;

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit counter with synchronous clear, increment and a
// combinational carry that fires when an increment rolls MAX back to 0.
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter int MAX = DIGIT_MAX
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [BCD_W-1:0] value,
  output logic             carry
);

  localparam logic [BCD_W-1:0] LAST = BCD_W'(MAX);

  // Carry out is asserted on the cycle this digit rolls over
  assign carry = inc && (value == LAST);

  // Digit register: clear wins over increment, increment wraps at MAX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc) begin
      if (value == LAST) begin
        value <= '0;
      end else begin
        value <= value + BCD_W'(1);
      end
    end
  end

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch time-keeping core: MM:SS counter from 00:00 to 99:59 with
// run/pause/adjust control, a 1 Hz run prescaler and an adjust-rate
// prescaler, all in the clk domain.
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100_000_000,
  parameter int ADJ_TICKS     = 50_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pause_p,
  input  logic             clear_p,
  input  logic             adj,
  input  logic             sel,
  output logic [BCD_W-1:0] min_l,
  output logic [BCD_W-1:0] min_r,
  output logic [BCD_W-1:0] sec_l,
  output logic [BCD_W-1:0] sec_r,
  output logic             running,
  output logic             wrap
);

  localparam int RUN_W = $clog2(TICKS_PER_SEC);
  localparam int ADJ_W = $clog2(ADJ_TICKS);

  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(TICKS_PER_SEC - 1);
  localparam logic [ADJ_W-1:0] ADJ_LAST = ADJ_W'(ADJ_TICKS - 1);

  state_t           state;
  logic [RUN_W-1:0] run_pre;
  logic [ADJ_W-1:0] adj_pre;

  logic run_tick;
  logic adj_tick;
  logic sec_r_inc, sec_l_inc, min_r_inc, min_l_inc;
  logic sec_r_carry, sec_l_carry, min_r_carry, min_l_carry;
  logic wrap_next;

  // Second and adjust ticks; clear and adjust entry suppress counting
  always_comb begin
    run_tick = (state == RUN) && !clear_p && !adj && (run_pre == RUN_LAST);
    adj_tick = (state == ADJUST) && adj && !clear_p && (adj_pre == ADJ_LAST);
  end

  // Digit increment chain; in adjust mode the carry into the other field
  // is cut so seconds wrap 59->00 and minutes wrap 99->00 on their own
  always_comb begin
    sec_r_inc = run_tick || (adj_tick && !sel);
    sec_l_inc = sec_r_carry;
    min_r_inc = (run_tick && sec_l_carry) || (adj_tick && sel);
    min_l_inc = min_r_carry;
    wrap_next = run_tick && min_l_carry;
  end

  // Control FSM with both prescalers and the registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= PAUSED;
      run_pre <= '0;
      adj_pre <= '0;
      running <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      wrap <= wrap_next;
      if (clear_p) begin
        run_pre <= '0;
        adj_pre <= '0;
        running <= 1'b0;
        state   <= adj ? ADJUST : PAUSED;
      end else if (adj) begin
        running <= 1'b0;
        state   <= ADJUST;
        if (state != ADJUST) begin
          run_pre <= '0;
          adj_pre <= '0;
        end else if (adj_tick) begin
          adj_pre <= '0;
        end else begin
          adj_pre <= adj_pre + ADJ_W'(1);
        end
      end else begin
        case (state)
          ADJUST: begin
            state   <= PAUSED;
            running <= 1'b0;
          end
          RUN: begin
            if (run_tick) begin
              run_pre <= '0;
            end else begin
              run_pre <= run_pre + RUN_W'(1);
            end
            if (pause_p) begin
              state   <= PAUSED;
              running <= 1'b0;
            end
          end
          PAUSED: begin
            if (pause_p) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          default: begin
            state   <= PAUSED;
            running <= 1'b0;
          end
        endcase
      end
    end
  end

  bcd_digit #(.MAX(DIGIT_MAX)) u_sec_r (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear_p),
    .inc   (sec_r_inc),
    .value (sec_r),
    .carry (sec_r_carry)
  );

  bcd_digit #(.MAX(SEC_TENS_MAX)) u_sec_l (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear_p),
    .inc   (sec_l_inc),
    .value (sec_l),
    .carry (sec_l_carry)
  );

  bcd_digit #(.MAX(DIGIT_MAX)) u_min_r (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear_p),
    .inc   (min_r_inc),
    .value (min_r),
    .carry (min_r_carry)
  );

  bcd_digit #(.MAX(DIGIT_MAX)) u_min_l (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear_p),
    .inc   (min_l_inc),
    .value (min_l),
    .carry (min_l_carry)
  );

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed testbench for stopwatch_counter with a 4-cycle second and a
// 2-cycle adjust interval; expected values are worked out by hand.
module tb_stopwatch_counter;

  logic       clk;
  logic       rst_n;
  logic       pause_p;
  logic       clear_p;
  logic       adj;
  logic       sel;
  logic [3:0] min_l, min_r, sec_l, sec_r;
  logic       running;
  logic       wrap;

  int tests_run;
  int tests_failed;

  logic [15:0] t;
  assign t = {min_l, min_r, sec_l, sec_r};

  stopwatch_counter #(
    .TICKS_PER_SEC (4),
    .ADJ_TICKS     (2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .pause_p (pause_p),
    .clear_p (clear_p),
    .adj     (adj),
    .sel     (sel),
    .min_l   (min_l),
    .min_r   (min_r),
    .sec_l   (sec_l),
    .sec_r   (sec_r),
    .running (running),
    .wrap    (wrap)
  );

  // Free-running 100 MHz-style clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and settle just after the last one
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_pause();
    pause_p = 1'b1;
    step(1);
    pause_p = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pause_p = 1'b0; clear_p = 1'b0; adj = 1'b0; sel = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
    tests_run++;
    if (t !== 16'h0000 || running !== 1'b0 || wrap !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_state: got %h run=%b wrap=%b, expected 0000 run=0 wrap=0", t, running, wrap);
    end
    pulse_pause();
    step(30);
    tests_run++;
    if (t !== 16'h0007 || running !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL pre_reset_count: got %h run=%b, expected 0007 run=1", t, running);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (t !== 16'h0000 || running !== 1'b0 || wrap !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL async_reset: got %h run=%b wrap=%b, expected 0000 run=0 wrap=0", t, running, wrap);
    end
    step(2);
    rst_n = 1'b1;
    step(3);
    tests_run++;
    if (t !== 16'h0000 || running !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_hold: got %h run=%b, expected 0000 run=0", t, running);
    end
  endtask

  task automatic test_run();
    pulse_pause();
    tests_run++;
    if (running !== 1'b1 || t !== 16'h0000) begin
      tests_failed++;
      $display("[TB] FAIL run_start: got %h run=%b, expected 0000 run=1", t, running);
    end
    step(3);
    tests_run++;
    if (t !== 16'h0000) begin
      tests_failed++;
      $display("[TB] FAIL first_sec_early: got %h, expected 0000", t);
    end
    step(1);
    tests_run++;
    if (t !== 16'h0001) begin
      tests_failed++;
      $display("[TB] FAIL first_sec: got %h, expected 0001", t);
    end
    step(236);
    tests_run++;
    if (t !== 16'h0100 || wrap !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL one_minute: got %h wrap=%b, expected 0100 wrap=0", t, wrap);
    end
  endtask

  task automatic test_wrap();
    adj = 1'b1; sel = 1'b1;
    step(1 + 196);
    tests_run++;
    if (t !== 16'h9900 || running !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL adj_min_99: got %h run=%b, expected 9900 run=0", t, running);
    end
    sel = 1'b0;
    step(118);
    tests_run++;
    if (t !== 16'h9959) begin
      tests_failed++;
      $display("[TB] FAIL adj_sec_59: got %h, expected 9959", t);
    end
    adj = 1'b0;
    step(1);
    pulse_pause();
    step(3);
    tests_run++;
    if (t !== 16'h9959 || wrap !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL pre_wrap: got %h wrap=%b, expected 9959 wrap=0", t, wrap);
    end
    step(1);
    tests_run++;
    if (t !== 16'h0000 || wrap !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL wrap_edge: got %h wrap=%b, expected 0000 wrap=1", t, wrap);
    end
    step(1);
    tests_run++;
    if (t !== 16'h0000 || wrap !== 1'b0 || running !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL wrap_pulse_end: got %h wrap=%b run=%b, expected 0000 wrap=0 run=1", t, wrap, running);
    end
  endtask

  task automatic test_adjust_limits();
    adj = 1'b1; sel = 1'b1; clear_p = 1'b1;
    step(1);
    clear_p = 1'b0;
    tests_run++;
    if (t !== 16'h0000 || running !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL adj_clear: got %h run=%b, expected 0000 run=0", t, running);
    end
    step(24);
    sel = 1'b0;
    step(118);
    tests_run++;
    if (t !== 16'h1259) begin
      tests_failed++;
      $display("[TB] FAIL adj_1259: got %h, expected 1259", t);
    end
    step(2);
    tests_run++;
    if (t !== 16'h1200) begin
      tests_failed++;
      $display("[TB] FAIL sec_wrap_no_carry: got %h, expected 1200", t);
    end
    sel = 1'b1;
    step(174);
    tests_run++;
    if (t !== 16'h9900) begin
      tests_failed++;
      $display("[TB] FAIL adj_9900: got %h, expected 9900", t);
    end
    step(2);
    tests_run++;
    if (t !== 16'h0000 || wrap !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL min_wrap_adj: got %h wrap=%b, expected 0000 wrap=0", t, wrap);
    end
  endtask

  task automatic test_pause_resume();
    adj = 1'b0;
    step(1);
    clear_p = 1'b1;
    step(1);
    clear_p = 1'b0;
    pulse_pause();
    step(4);
    tests_run++;
    if (t !== 16'h0001) begin
      tests_failed++;
      $display("[TB] FAIL boundary: got %h, expected 0001", t);
    end
    step(1);
    pulse_pause();
    tests_run++;
    if (running !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL paused: got run=%b, expected 0", running);
    end
    step(100);
    tests_run++;
    if (t !== 16'h0001) begin
      tests_failed++;
      $display("[TB] FAIL frozen: got %h, expected 0001", t);
    end
    pulse_pause();
    step(1);
    tests_run++;
    if (t !== 16'h0001 || running !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL resume_early: got %h run=%b, expected 0001 run=1", t, running);
    end
    step(1);
    tests_run++;
    if (t !== 16'h0002) begin
      tests_failed++;
      $display("[TB] FAIL resume_fraction: got %h, expected 0002", t);
    end
  endtask

  task automatic test_back_to_back();
    adj = 1'b1; clear_p = 1'b1;
    step(1);
    clear_p = 1'b0; sel = 1'b1;
    step(6);
    sel = 1'b0;
    step(42);
    adj = 1'b0;
    step(1);
    pulse_pause();
    step(2);
    tests_run++;
    if (t !== 16'h0321 || running !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL setup_0321: got %h run=%b, expected 0321 run=1", t, running);
    end
    clear_p = 1'b1; pause_p = 1'b1;
    step(1);
    clear_p = 1'b0; pause_p = 1'b0;
    tests_run++;
    if (t !== 16'h0000 || running !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL clear_over_pause: got %h run=%b, expected 0000 run=0", t, running);
    end
    step(5);
    tests_run++;
    if (t !== 16'h0000) begin
      tests_failed++;
      $display("[TB] FAIL clear_idle: got %h, expected 0000", t);
    end
    pulse_pause();
    step(3);
    tests_run++;
    if (t !== 16'h0000 || running !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL restart_early: got %h run=%b, expected 0000 run=1", t, running);
    end
    step(1);
    tests_run++;
    if (t !== 16'h0001) begin
      tests_failed++;
      $display("[TB] FAIL restart_full_sec: got %h, expected 0001", t);
    end
  endtask

  // Run every scenario in order and report the totals
  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_run();
    test_wrap();
    test_adjust_limits();
    test_pause_resume();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
